// File: rtl/adder_pkg.sv
// Shared definitions for the sequential chunked adder: FSM encoding, opcodes,
// and sizing helpers used by the top level.
package adder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  // Number of CHUNK-bit slices making up a WIDTH-bit operand.
  function automatic int unsigned nchunk(input int unsigned width, input int unsigned chunk);
    return width / chunk;
  endfunction

  // Width of the slice index register; never below one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/ripple_chunk_adder.sv
// Combinational CHUNK-bit ripple-carry adder built from 1-bit full adders.
// Ports:
//   a, b   : CHUNK-bit addends
//   c_in   : carry into bit 0
//   sum    : CHUNK-bit result
//   carry  : carry out of the top bit
//   c_msb  : carry into the top bit (for signed overflow detection)
module ripple_chunk_adder #(
  parameter int unsigned CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             c_in,
  output logic [CHUNK-1:0] sum,
  output logic             carry,
  output logic             c_msb
);

  logic [CHUNK:0] c;

  // Full-adder ripple; c[i] is the carry into bit i.
  always_comb begin
    c    = '0;
    sum  = '0;
    c[0] = c_in;
    for (int i = 0; i < int'(CHUNK); i++) begin
      sum[i]  = a[i] ^ b[i] ^ c[i];
      c[i+1]  = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
  end

  assign carry = c[CHUNK];
  assign c_msb = c[CHUNK-1];

endmodule

// File: rtl/seq_chunk_adder.sv
// Multi-cycle adder/subtractor: WIDTH-bit operands summed CHUNK bits per clock
// through a registered carry, with valid/ready handshakes on both sides.
// Ports:
//   clk, rst             : clock (rising edge), synchronous active-high reset
//   in_valid / in_ready  : operand handshake (in_ready is combinational)
//   a, b, c_in, op       : operands, carry/borrow-in, 0 = add / 1 = subtract
//   out_valid / out_ready: result handshake
//   sum, carry, overflow : result, carry-out (1 = no borrow), signed overflow
module seq_chunk_adder
  import adder_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  input  logic             op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic             overflow
);

  localparam int unsigned NCHUNK = nchunk(WIDTH, CHUNK);
  localparam int unsigned IW     = idx_width(NCHUNK);

  state_t           state;
  logic [IW-1:0]    idx;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH-1:0] acc;
  logic             carry_reg;

  logic [31:0]      base;
  logic [CHUNK-1:0] a_slice;
  logic [CHUNK-1:0] b_slice;
  logic [CHUNK-1:0] s_slice;
  logic             c_slice;
  logic             c_msb;
  logic [WIDTH-1:0] acc_next;
  logic             last;
  logic             accept;

  assign in_ready = (state == ST_IDLE) || ((state == ST_DONE) && out_ready);
  assign accept   = in_valid && in_ready;
  assign last     = (idx == IW'(NCHUNK - 1));

  // Select the operand slices addressed by the current chunk index.
  assign base    = 32'(idx) * CHUNK;
  assign a_slice = a_reg[base +: CHUNK];
  assign b_slice = b_reg[base +: CHUNK];

  ripple_chunk_adder #(.CHUNK(CHUNK)) u_slice (
    .a     (a_slice),
    .b     (b_slice),
    .c_in  (carry_reg),
    .sum   (s_slice),
    .carry (c_slice),
    .c_msb (c_msb)
  );

  // Accumulator with the current slice merged in, so the final chunk lands in sum directly.
  always_comb begin
    acc_next               = acc;
    acc_next[base +: CHUNK] = s_slice;
  end

  // Control FSM and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      idx       <= '0;
      a_reg     <= '0;
      b_reg     <= '0;
      acc       <= '0;
      carry_reg <= 1'b0;
      out_valid <= 1'b0;
      sum       <= '0;
      carry     <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      unique case (state)
        ST_RUN: begin
          acc       <= acc_next;
          carry_reg <= c_slice;
          idx       <= idx + IW'(1);
          if (last) begin
            sum       <= acc_next;
            carry     <= c_slice;
            overflow  <= c_slice ^ c_msb;
            out_valid <= 1'b1;
            state     <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase

      // Accept overrides the IDLE/DONE transitions above (back-to-back included).
      if (accept) begin
        a_reg     <= a;
        b_reg     <= b ^ {WIDTH{op}};
        carry_reg <= c_in ^ op;
        idx       <= '0;
        state     <= ST_RUN;
      end
    end
  end

endmodule

// File: tb/tb_seq_chunk_adder.sv
// Directed self-checking bench for seq_chunk_adder (WIDTH=16, CHUNK=4).
module tb_seq_chunk_adder;

  localparam int unsigned WIDTH = 16;
  localparam int unsigned CHUNK = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             c_in;
  logic             op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             carry;
  logic             overflow;

  int n_checks = 0;
  int n_fail   = 0;

  seq_chunk_adder #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .c_in      (c_in),
    .op        (op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .carry     (carry),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  // Advance one edge, then settle away from it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present one operation with out_ready=1 and check latency and result.
  task automatic run_op(input string tag, input logic [15:0] va, input logic [15:0] vb,
                        input logic vc, input logic vop, input logic [15:0] es,
                        input logic ec, input logic eo);
    a = va; b = vb; c_in = vc; op = vop; in_valid = 1'b1; out_ready = 1'b1;
    check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    step();
    in_valid = 1'b0; a = 16'hDEAD; b = 16'hBEEF;
    for (int i = 1; i <= 4; i++) begin
      step();
      if (i < 4) check({tag, "_early_valid"}, 32'(out_valid), 32'd0);
    end
    check({tag, "_valid"}, 32'(out_valid), 32'd1);
    check({tag, "_sum"}, 32'(sum), 32'(es));
    check({tag, "_carry"}, 32'(carry), 32'(ec));
    check({tag, "_ovf"}, 32'(overflow), 32'(eo));
    step();
    check({tag, "_handoff"}, 32'(out_valid), 32'd0);
    check({tag, "_hold"}, 32'(sum), 32'(es));
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; c_in = 1'b0; op = 1'b0; out_ready = 1'b0;

    // Reset
    step(); step();
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_sum", 32'(sum), 32'h0);
    check("rst_carry", 32'(carry), 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) step();
    check("idle_valid", 32'(out_valid), 32'd0);
    check("idle_sum", 32'(sum), 32'h0);
    check("idle_in_ready", 32'(in_ready), 32'd1);

    // Add
    run_op("add", 16'h0002, 16'h0003, 1'b0, 1'b0, 16'h0005, 1'b0, 1'b0);
    run_op("add_ci", 16'h0002, 16'h0003, 1'b1, 1'b0, 16'h0006, 1'b0, 1'b0);

    // Cross-chunk carry
    run_op("wrap", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    run_op("ovf_add", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
    run_op("chunk_carry", 16'h0008, 16'h0007, 1'b1, 1'b0, 16'h0010, 1'b0, 1'b0);

    // Subtract
    run_op("sub", 16'h0008, 16'h0007, 1'b0, 1'b1, 16'h0001, 1'b1, 1'b0);
    run_op("sub_borrow", 16'h0000, 16'h0001, 1'b0, 1'b1, 16'hFFFF, 1'b0, 1'b0);
    run_op("sub_ovf", 16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);

    // Backpressure then back-to-back accept
    a = 16'h00FF; b = 16'h0001; c_in = 1'b0; op = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) step();
    check("bp_valid", 32'(out_valid), 32'd1);
    check("bp_sum", 32'(sum), 32'h0100);
    for (int i = 0; i < 3; i++) begin
      step();
      check("bp_hold_valid", 32'(out_valid), 32'd1);
      check("bp_hold_sum", 32'(sum), 32'h0100);
      check("bp_hold_carry", 32'(carry), 32'd0);
      check("bp_in_ready", 32'(in_ready), 32'd0);
    end
    a = 16'h1234; b = 16'h1111; in_valid = 1'b1; out_ready = 1'b1;
    #1;
    check("b2b_in_ready", 32'(in_ready), 32'd1);
    step();
    in_valid = 1'b0;
    check("b2b_drop", 32'(out_valid), 32'd0);
    check("b2b_old_sum", 32'(sum), 32'h0100);
    for (int i = 1; i <= 4; i++) begin
      step();
      if (i < 4) check("b2b_early_valid", 32'(out_valid), 32'd0);
    end
    check("b2b_valid", 32'(out_valid), 32'd1);
    check("b2b_sum", 32'(sum), 32'h2345);
    step();

    // Reset during RUN: result must never surface
    rst = 1'b1; step(); rst = 1'b0;
    a = 16'hFFFF; b = 16'h0001; c_in = 1'b0; op = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_in_ready", 32'(in_ready), 32'd1);
    check("mid_rst_sum", 32'(sum), 32'h0);
    check("mid_rst_carry", 32'(carry), 32'd0);
    for (int i = 0; i < 6; i++) begin
      step();
      check("mid_rst_no_stale", 32'(out_valid), 32'd0);
    end
    check("mid_rst_sum_after", 32'(sum), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/seq_chunk_adder.md
Name: seq_chunk_adder

Overview:
Parametrised multi-cycle adder/subtractor: WIDTH-bit operands are summed CHUNK bits per clock through a registered carry chain.
- Trades latency for a short combinational path on wide datapaths.
- Adds a subtract mode, a signed-overflow flag, and valid/ready handshakes on both sides.
- Sits between operand producers and result consumers in datapaths wider than a single-cycle ripple adder can close timing on.

Parameters:
WIDTH, 16, operand and result width in bits; must be a multiple of CHUNK.
CHUNK, 4, bits summed per clock by the internal ripple slice; 1 <= CHUNK <= WIDTH.

Ports:
clk  input  1  clock, rising edge.
rst  input  1  synchronous, active-high reset.
in_valid  input  1  operands present.
in_ready  output  1  block accepts operands this cycle.
a  input  WIDTH  operand A.
b  input  WIDTH  operand B.
c_in  input  1  carry-in (add) / borrow-in (subtract).
op  input  1  0 = add (a+b+c_in); 1 = subtract (a-b-c_in).
out_valid  output  1  result available.
out_ready  input  1  consumer takes result this cycle.
sum  output  WIDTH  result.
carry  output  1  carry-out; in subtract mode 1 = no borrow.
overflow  output  1  signed two's-complement overflow.

Behaviour:
- NCHUNK = WIDTH/CHUNK.
- State machine: IDLE, RUN, DONE.
- Reset (rst high at a clock edge): state IDLE, chunk index 0, out_valid/sum/carry/overflow = 0. Reset dominates every other event, including mid-RUN and DONE; any in-flight operation is discarded silently.
- in_ready is combinational: (state==IDLE) || (state==DONE && out_ready). It never depends on in_valid.
- Accept occurs on an edge where in_valid && in_ready. On accept:
  - latch a, b_eff = b ^ {WIDTH{op}};
  - carry register = c_in ^ op;
  - index = 0; state goes to RUN.
  - Inputs are ignored while not accepting.
- RUN, one chunk per edge:
  - {c, s} = a[idx] + b_eff[idx] + carry_reg;
  - s is written into the accumulator slice idx; carry_reg = c;
  - idx increments.
  - On the edge processing idx = NCHUNK-1:
    - sum, carry and overflow registers are loaded;
    - overflow = carry into the MSB XOR carry out of the MSB;
    - state goes to DONE; out_valid = 1.
- Latency: accept at edge k gives out_valid high after edge k+NCHUNK. NCHUNK=1 gives one RUN cycle.
- DONE: out_valid = 1, and sum/carry/overflow are held stable while out_ready = 0.
  - On an edge with out_ready: if a new accept happens the same edge, go to RUN (back-to-back, out_valid drops to 0); otherwise go to IDLE with out_valid = 0.
- sum/carry/overflow keep the last result after handoff until the next completion overwrites them.
- Arithmetic is modulo 2^WIDTH; there is no saturation.

Decomposition:
- Shared package adder_pkg holds:
  - state encoding (IDLE=0, RUN=1, DONE=2, 2-bit);
  - OP_ADD=1'b0, OP_SUB=1'b1;
  - function nchunk(WIDTH, CHUNK);
  - index-width helper (clog2 of NCHUNK, minimum 1).
- One sub-module, ripple_chunk_adder (parameter CHUNK): a combinational CHUNK-bit ripple of 1-bit full adders.
  - Inputs a, b, c_in.
  - Outputs sum, carry, and c_msb (the carry into its top bit), used for overflow on the last chunk.
- The top level instantiates it once and muxes slices by index.

Test Plan:
Use WIDTH=16, CHUNK=4 throughout.
1. Reset: assert rst 2 cycles -> out_valid=0, sum=0x0000, carry=0, overflow=0, in_ready=1; deassert, no activity -> outputs unchanged.
2. Add: a=0x0002, b=0x0003, c_in=0, op=0, out_ready=1 -> out_valid after exactly 4 edges, sum=0x0005, carry=0, overflow=0. Repeat with c_in=1 -> 0x0006.
3. Cross-chunk carry:
   - 0xFFFF+0x0001 -> sum=0x0000, carry=1, overflow=0.
   - 0x7FFF+0x0001 -> sum=0x8000, carry=0, overflow=1.
   - 0x0008+0x0007, c_in=1 -> 0x0010.
4. Subtract (op=1):
   - 0x0008-0x0007, c_in=0 -> 0x0001, carry=1.
   - 0x0000-0x0001 -> 0xFFFF, carry=0, overflow=0.
   - 0x8000-0x0001 -> 0x7FFF, overflow=1.
5. Backpressure and back-to-back:
   - Hold out_ready=0 for 3 cycles after out_valid -> sum/carry stable, in_ready=0.
   - Then raise out_ready with in_valid=1 (a=0x1234, b=0x1111) -> accept on the same edge, out_valid drops next cycle, 0x2345 valid 4 edges later.
6. Reset mid-operation: accept 0xFFFF+0x0001, assert rst on the 2nd RUN edge -> next cycle state IDLE, out_valid=0, in_ready=1, sum=0x0000; no stale result ever appears.
